// File: rtl/motoro3_commutation_seq_if.sv
// Interface bundle for motoro3_commutation_seq.
// Optional feature macro: MOTORO3_BRAKE_EN (adds the brake request line).
// Signals:
//   run, dir, stepPulse, fault, [brake]  - control inputs to the sequencer
//   mosEnable[2:0] {C,B,A}                - per-phase driver enable
//   h1_L0[2:0]     {C,B,A}                - per-phase side select, 1 = high side
//   stepIdx[2:0]                          - current commutation step 0..5
//   busy                                  - dead-time in progress
//   stepMiss                              - one-cycle pulse, stepPulse dropped
// Modports: master = controller side, slave = sequencer side.
interface motoro3_commutation_seq_if;
  logic       run;
  logic       dir;
  logic       stepPulse;
  logic       fault;
`ifdef MOTORO3_BRAKE_EN
  logic       brake;
`endif
  logic [2:0] mosEnable;
  logic [2:0] h1_L0;
  logic [2:0] stepIdx;
  logic       busy;
  logic       stepMiss;

  modport master (
    output run, dir, stepPulse, fault,
`ifdef MOTORO3_BRAKE_EN
    output brake,
`endif
    input  mosEnable, h1_L0, stepIdx, busy, stepMiss
  );

  modport slave (
    input  run, dir, stepPulse, fault,
`ifdef MOTORO3_BRAKE_EN
    input  brake,
`endif
    output mosEnable, h1_L0, stepIdx, busy, stepMiss
  );
endinterface

// File: rtl/motoro3_commutation_seq.sv
// Six-step BLDC commutation sequencer with dead-time insertion.
// Optional feature macro: MOTORO3_BRAKE_EN (brake input and BRAKE state:
// all three low sides on, entered and left through a full dead-time).
// Ports:
//   clk  - 10 MHz system clock, rising edge
//   rst  - synchronous, active-high reset
//   bus  - motoro3_commutation_seq_if.slave (control inputs, registered outputs)
// Parameter:
//   DEADTIME - dead-time length in clk cycles, 1..255
module motoro3_commutation_seq #(
  parameter int unsigned DEADTIME = 20
) (
  input logic                        clk,
  input logic                        rst,
  motoro3_commutation_seq_if.slave   bus
);

  typedef enum logic [2:0] {
    IDLE,
    DEAD,
    DRIVE,
    FAULT
`ifdef MOTORO3_BRAKE_EN
    , BRAKE
`endif
  } state_t;

  localparam logic [7:0] DT_LOAD = 8'(DEADTIME - 1);

  state_t     state, state_n;
  logic [7:0] cnt, cnt_n;
  logic [2:0] step, step_n, step_adv;
  logic [2:0] en, en_n, h, h_n;
  logic [2:0] en_old, h_old, en_new, h_new;
  logic       busy_q, busy_n, miss_q, miss_n;
`ifdef MOTORO3_BRAKE_EN
  logic       to_brake, to_brake_n;
`endif

  // {en[2:0], h[2:0]} for each step, phases ordered {C,B,A}
  function automatic logic [5:0] step_pat(input logic [2:0] s);
    case (s)
      3'd0:    step_pat = {3'b011, 3'b001};
      3'd1:    step_pat = {3'b101, 3'b001};
      3'd2:    step_pat = {3'b110, 3'b010};
      3'd3:    step_pat = {3'b011, 3'b010};
      3'd4:    step_pat = {3'b101, 3'b100};
      3'd5:    step_pat = {3'b110, 3'b100};
      default: step_pat = '0;
    endcase
  endfunction

  always_comb begin
    if (bus.dir) step_adv = (step == 3'd5) ? 3'd0 : step + 3'd1;
    else         step_adv = (step == 3'd0) ? 3'd5 : step - 3'd1;
    {en_old, h_old} = step_pat(step);
    {en_new, h_new} = step_pat(step_adv);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      step     <= '0;
      en       <= '0;
      h        <= '0;
      busy_q   <= 1'b0;
      miss_q   <= 1'b0;
`ifdef MOTORO3_BRAKE_EN
      to_brake <= 1'b0;
`endif
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      step     <= step_n;
      en       <= en_n;
      h        <= h_n;
      busy_q   <= busy_n;
      miss_q   <= miss_n;
`ifdef MOTORO3_BRAKE_EN
      to_brake <= to_brake_n;
`endif
    end
  end

  // Outputs are registered: this block computes the value each output takes
  // after the edge. During DEAD the output registers simply hold the mask
  // that was loaded on entry.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    step_n  = step;
    en_n    = en;
    h_n     = h;
    busy_n  = 1'b0;
    miss_n  = 1'b0;
`ifdef MOTORO3_BRAKE_EN
    to_brake_n = to_brake;
`endif
    case (state)
      IDLE: begin
        en_n = '0;
        h_n  = '0;
        if (bus.run) begin
          state_n = DEAD;
          cnt_n   = DT_LOAD;
          busy_n  = 1'b1;
`ifdef MOTORO3_BRAKE_EN
          to_brake_n = 1'b0;
`endif
        end
      end
      DEAD: begin
        miss_n = bus.stepPulse;
        if (cnt == 8'd0) begin
`ifdef MOTORO3_BRAKE_EN
          if (to_brake) begin
            state_n = BRAKE;
            en_n    = 3'b111;
            h_n     = 3'b000;
          end else
`endif
          begin
            state_n     = DRIVE;
            {en_n, h_n} = step_pat(step);
          end
        end else begin
          cnt_n  = cnt - 8'd1;
          busy_n = 1'b1;
        end
      end
      DRIVE: begin
`ifdef MOTORO3_BRAKE_EN
        if (bus.brake) begin
          state_n    = DEAD;
          cnt_n      = DT_LOAD;
          busy_n     = 1'b1;
          en_n       = '0;
          h_n        = '0;
          to_brake_n = 1'b1;
        end else
`endif
        if (bus.stepPulse) begin
          state_n = DEAD;
          cnt_n   = DT_LOAD;
          busy_n  = 1'b1;
          step_n  = step_adv;
          // Only a phase whose (en,h) is unchanged may stay on.
          en_n    = en_old & en_new & ~(h_old ^ h_new);
          h_n     = h_old & en_n;
        end
      end
`ifdef MOTORO3_BRAKE_EN
      BRAKE: begin
        if (!bus.brake) begin
          state_n    = DEAD;
          cnt_n      = DT_LOAD;
          busy_n     = 1'b1;
          en_n       = '0;
          h_n        = '0;
          to_brake_n = 1'b0;
        end
      end
`endif
      FAULT: begin
        en_n = '0;
        h_n  = '0;
        if (!bus.run) state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
        en_n    = '0;
        h_n     = '0;
      end
    endcase

    // run=0 and fault override any transition chosen above; fault wins.
    if (!bus.run && state != IDLE && state != FAULT) begin
      state_n = IDLE;
      step_n  = step;
      en_n    = '0;
      h_n     = '0;
      busy_n  = 1'b0;
    end
    if (bus.fault) begin
      state_n = FAULT;
      step_n  = step;
      en_n    = '0;
      h_n     = '0;
      busy_n  = 1'b0;
    end
  end

  assign bus.mosEnable = en;
  assign bus.h1_L0     = h;
  assign bus.stepIdx   = step;
  assign bus.busy      = busy_q;
  assign bus.stepMiss  = miss_q;

endmodule

// File: tb/tb_motoro3_commutation_seq.sv
// Self-checking bench for motoro3_commutation_seq (DEADTIME = 20).
// Table of {inputs, hold cycles, expected outputs} records plus hand-written
// step/dead-time sequences; brake sequence only with MOTORO3_BRAKE_EN.
module tb_motoro3_commutation_seq;
  localparam int DT = 20;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #50 clk = ~clk;

  motoro3_commutation_seq_if bus ();

  motoro3_commutation_seq #(.DEADTIME(DT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    logic       rst, run, dir, sp, fault;
    int         n;
    logic [2:0] en, h, idx;
    logic       busy, miss;
  } vec_t;

  vec_t tbl[$];
  vec_t exp_q[$];
  int   checks = 0;
  int   failures = 0;

  function automatic vec_t mk(input logic r, input logic ru, input logic d,
                              input logic s, input logic f, input int n,
                              input logic [2:0] en, input logic [2:0] h,
                              input logic [2:0] idx, input logic b, input logic m);
    vec_t v;
    v.rst = r; v.run = ru; v.dir = d; v.sp = s; v.fault = f; v.n = n;
    v.en = en; v.h = h; v.idx = idx; v.busy = b; v.miss = m;
    return v;
  endfunction

  // Expected pattern from the step's high/low phase numbers (A=0,B=1,C=2).
  function automatic logic [5:0] ref_pat(input int s);
    int hi[6] = '{0, 0, 1, 1, 2, 2};
    int lo[6] = '{1, 2, 2, 0, 0, 1};
    logic [2:0] e, hh;
    e  = 3'(1 << hi[s]) | 3'(1 << lo[s]);
    hh = 3'(1 << hi[s]);
    return {e, hh};
  endfunction

  task automatic chk(input string name, input logic [2:0] got, input logic [2:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%b expected=%b", name, got, want);
    end
  endtask

  task automatic drive(input vec_t v);
    rst           = v.rst;
    bus.run       = v.run;
    bus.dir       = v.dir;
    bus.fault     = v.fault;
    bus.stepPulse = v.sp;
    @(posedge clk); #1;
    bus.stepPulse = 1'b0;
    for (int k = 1; k < v.n; k++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic compare(input vec_t v, input int i);
    chk($sformatf("v%0d mosEnable", i), bus.mosEnable, v.en);
    chk($sformatf("v%0d h1_L0", i), bus.h1_L0, v.h);
    chk($sformatf("v%0d stepIdx", i), bus.stepIdx, v.idx);
    chk($sformatf("v%0d busy", i), {2'b0, bus.busy}, {2'b0, v.busy});
    chk($sformatf("v%0d stepMiss", i), {2'b0, bus.stepMiss}, {2'b0, v.miss});
  endtask

  // Per-phase shoot-through monitor state
  logic       had_on[3];
  logic       last_side[3];
  int         off_run[3];
  int         violations = 0;

  task automatic monitor();
    for (int p = 0; p < 3; p++) begin
      if (bus.mosEnable[p]) begin
        if (had_on[p] && bus.h1_L0[p] != last_side[p] && off_run[p] < DT)
          violations++;
        had_on[p] = 1'b1;
        last_side[p] = bus.h1_L0[p];
        off_run[p] = 0;
      end else begin
        off_run[p]++;
      end
    end
  endtask

  initial begin
    bus.run = 1'b0; bus.dir = 1'b1; bus.stepPulse = 1'b0; bus.fault = 1'b0;
`ifdef MOTORO3_BRAKE_EN
    bus.brake = 1'b0;
`endif
    //            rst run dir sp flt  n   en      h       idx  busy miss
    tbl.push_back(mk(1, 0, 0, 0, 0,  2, 3'b000, 3'b000, 3'd0, 0, 0)); // reset
    tbl.push_back(mk(0, 1, 1, 0, 0,  1, 3'b000, 3'b000, 3'd0, 1, 0)); // enter DEAD
    tbl.push_back(mk(0, 1, 1, 0, 0, 19, 3'b000, 3'b000, 3'd0, 1, 0)); // 20th busy cycle
    tbl.push_back(mk(0, 1, 1, 0, 0,  1, 3'b011, 3'b001, 3'd0, 0, 0)); // step 0
    tbl.push_back(mk(0, 1, 1, 1, 0,  1, 3'b001, 3'b001, 3'd1, 1, 0)); // A held
    tbl.push_back(mk(0, 1, 1, 0, 0, 19, 3'b001, 3'b001, 3'd1, 1, 0));
    tbl.push_back(mk(0, 1, 1, 0, 0,  1, 3'b101, 3'b001, 3'd1, 0, 0)); // step 1
    tbl.push_back(mk(0, 1, 0, 1, 0,  1, 3'b001, 3'b001, 3'd0, 1, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 20, 3'b011, 3'b001, 3'd0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 1, 0,  1, 3'b010, 3'b000, 3'd5, 1, 0)); // 0 -> 5, B held low
    tbl.push_back(mk(0, 1, 0, 0, 0, 20, 3'b110, 3'b100, 3'd5, 0, 0));
    tbl.push_back(mk(0, 1, 1, 1, 0,  1, 3'b010, 3'b000, 3'd0, 1, 0)); // 5 -> 0 wrap
    tbl.push_back(mk(0, 1, 1, 0, 0, 20, 3'b011, 3'b001, 3'd0, 0, 0));
    tbl.push_back(mk(0, 1, 1, 1, 0,  5, 3'b001, 3'b001, 3'd1, 1, 0));
    tbl.push_back(mk(0, 1, 1, 1, 0,  1, 3'b001, 3'b001, 3'd1, 1, 1)); // dropped pulse
    tbl.push_back(mk(0, 1, 1, 0, 0,  1, 3'b001, 3'b001, 3'd1, 1, 0));
    tbl.push_back(mk(0, 1, 1, 0, 0, 14, 3'b101, 3'b001, 3'd1, 0, 0)); // dead-time unchanged
    tbl.push_back(mk(0, 0, 1, 0, 0,  1, 3'b000, 3'b000, 3'd1, 0, 0)); // run=0 -> IDLE
    tbl.push_back(mk(0, 0, 1, 1, 0,  2, 3'b000, 3'b000, 3'd1, 0, 0)); // pulse ignored
    tbl.push_back(mk(0, 1, 1, 0, 0,  1, 3'b000, 3'b000, 3'd1, 1, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0,  1, 3'b000, 3'b000, 3'd1, 0, 0)); // run=0 mid-DEAD
    tbl.push_back(mk(0, 1, 1, 0, 0, 21, 3'b101, 3'b001, 3'd1, 0, 0));
    tbl.push_back(mk(0, 1, 1, 1, 1,  1, 3'b000, 3'b000, 3'd1, 0, 0)); // fault beats pulse
    tbl.push_back(mk(0, 1, 1, 0, 0,  3, 3'b000, 3'b000, 3'd1, 0, 0)); // stays FAULT
    tbl.push_back(mk(0, 0, 1, 0, 0,  1, 3'b000, 3'b000, 3'd1, 0, 0)); // -> IDLE
    tbl.push_back(mk(0, 1, 1, 0, 0,  1, 3'b000, 3'b000, 3'd1, 1, 0));
    tbl.push_back(mk(0, 1, 1, 0, 1,  1, 3'b000, 3'b000, 3'd1, 0, 0)); // fault in DEAD
    tbl.push_back(mk(1, 1, 1, 0, 1,  1, 3'b000, 3'b000, 3'd0, 0, 0)); // rst beats fault
    tbl.push_back(mk(0, 1, 1, 0, 0,  1, 3'b000, 3'b000, 3'd0, 1, 0));
    tbl.push_back(mk(0, 1, 1, 0, 0,  5, 3'b000, 3'b000, 3'd0, 1, 0));
    tbl.push_back(mk(1, 1, 1, 0, 0,  1, 3'b000, 3'b000, 3'd0, 0, 0)); // rst mid-DEAD
    tbl.push_back(mk(0, 1, 1, 0, 0, 21, 3'b011, 3'b001, 3'd0, 0, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i]);
      exp_q.push_back(tbl[i]);
      @(negedge clk);
      compare(exp_q.pop_front(), i);
    end

    // Twelve steps (six forward, six reverse): dead-time length, final
    // pattern and phase side-change safety.
    begin
      int   exp_idx;
      int   busy_cnt;
      logic [5:0] pat;
      exp_idx = 0;
      for (int p = 0; p < 3; p++) begin
        had_on[p] = 1'b0; last_side[p] = 1'b0; off_run[p] = 0;
      end
      monitor();
      for (int r = 0; r < 12; r++) begin
        bus.dir = (r < 6);
        exp_idx = (r < 6) ? (exp_idx + 1) % 6 : (exp_idx + 5) % 6;
        bus.stepPulse = 1'b1;
        @(posedge clk); #1;
        bus.stepPulse = 1'b0;
        busy_cnt = 0;
        for (int c = 0; c < 3 * DT; c++) begin
          @(negedge clk);
          monitor();
          if (bus.busy) busy_cnt++;
          else break;
        end
        pat = ref_pat(exp_idx);
        chk($sformatf("seq%0d busy_len", r), 3'(busy_cnt == DT), 3'd1);
        chk($sformatf("seq%0d stepIdx", r), bus.stepIdx, 3'(exp_idx));
        chk($sformatf("seq%0d mosEnable", r), bus.mosEnable, pat[5:3]);
        chk($sformatf("seq%0d h1_L0", r), bus.h1_L0, pat[2:0]);
      end
      chk("side_change_without_deadtime", 3'(violations), 3'd0);
    end

`ifdef MOTORO3_BRAKE_EN
    begin
      logic [5:0] pat;
      bus.brake = 1'b1;
      @(posedge clk); #1;
      repeat (DT - 1) @(posedge clk);
      @(negedge clk);
      chk("brake dead en", bus.mosEnable, 3'b000);
      chk("brake dead busy", {2'b0, bus.busy}, 3'b001);
      @(negedge clk);
      chk("brake en", bus.mosEnable, 3'b111);
      chk("brake h", bus.h1_L0, 3'b000);
      bus.brake = 1'b0;
      @(posedge clk); #1;
      chk("unbrake off", bus.mosEnable, 3'b000);
      repeat (DT) @(posedge clk);
      @(negedge clk);
      pat = ref_pat(int'(bus.stepIdx));
      chk("unbrake stepIdx", bus.stepIdx, 3'd0);
      chk("unbrake en", bus.mosEnable, pat[5:3]);
      chk("unbrake h", bus.h1_L0, pat[2:0]);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute time bound in case a sequence stalls.
  initial begin
    #20000000;
    $display("FAIL timeout reached without completing the sequence");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end
endmodule
